// File: rtl/tc_pkg.sv
// Shared constants for the tc_timer down-counter peripheral: FSM state codes,
// register offsets, CTRL bit positions and MODE encodings.
package tc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Word offsets as seen on addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;
    localparam logic [1:0] OFF_NONE   = 2'b11;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Only the exact 01 encoding reloads; 1x falls back to one-shot.
    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/tc_timer_if.sv
// Register-bus connection between the system bridge (master) and a timer (slave).
// Bus semantics: no handshake; a write happens on every clk edge with we=1, and
// rdata/irq are combinational views of the slave's registers, valid every cycle.
interface tc_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped down-counter timer with one-shot and auto-reload modes.
// Optional build macro TC_STATUS_READ_EN exposes FSM state and irq_flag in CTRL[6:4].
module tc_timer
    import tc_pkg::*;
#(
    parameter int              CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    tc_timer_if.slave  bus,
    output logic [1:0] state_dbg
);

    logic             en_q;
    logic             im_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       state_q;
    logic             flag_q;

    logic [1:0] off;
    logic       ctrl_wr;
    logic       preset_wr;
    logic       expire;
    logic       unused_addr_bits;

    assign off              = bus.addr[3:2];
    assign ctrl_wr          = bus.we && (off == OFF_CTRL);
    assign preset_wr        = bus.we && (off == OFF_PRESET);
    assign expire           = (state_q == ST_CNT) && en_q && (count_q <= CNT_W'(1));
    assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (en_q) state_q <= ST_LOAD;
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en_q) begin
                        state_q <= ST_IDLE;
                    end else if (count_q > CNT_W'(1)) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        count_q <= '0;
                        state_q <= ST_INT;
                    end
                end
                ST_INT:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A CTRL write always beats the one-shot auto-disable of EN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q   <= 1'b0;
            mode_q <= MODE_ONESHOT;
            im_q   <= 1'b0;
        end else if (ctrl_wr) begin
            en_q   <= bus.wdata[CTRL_EN];
            mode_q <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im_q   <= bus.wdata[CTRL_IM];
        end else if (state_q == ST_INT && !is_auto(mode_q)) begin
            en_q   <= 1'b0;
        end
    end

    // Expiry wins over a same-cycle CTRL write: the write only clears the old flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
        end else if (expire) begin
            flag_q <= 1'b1;
        end else if (ctrl_wr) begin
            flag_q <= 1'b0;
        end else if (state_q == ST_INT && is_auto(mode_q)) begin
            flag_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preset_q <= PRESET_RST;
        end else if (preset_wr) begin
            preset_q <= CNT_W'(bus.wdata);
        end
    end

    logic [31:0] ctrl_rd;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN]                  = en_q;
        ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        ctrl_rd[CTRL_IM]                  = im_q;
`ifdef TC_STATUS_READ_EN
        ctrl_rd[5:4] = state_q;
        ctrl_rd[6]   = flag_q;
`endif
    end

    always_comb begin
        bus.rdata = '0;
        case (off)
            OFF_CTRL:   bus.rdata = ctrl_rd;
            OFF_PRESET: bus.rdata = 32'(preset_q);
            OFF_COUNT:  bus.rdata = 32'(count_q);
            default:    bus.rdata = '0;
        endcase
    end

    assign bus.irq   = im_q & flag_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tc_timer.sv
// Testbench for tc_timer: directed scenarios plus random register traffic,
// all checked against a cycle-level behavioural model of the timer rules.
module tb_tc_timer;

  typedef enum int {P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3} phase_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] state_dbg;

  tc_timer_if bus ();

  tc_timer #(.CNT_W(32), .PRESET_RST(32'h0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  phase_t      m_ph;
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] off);
    logic [31:0] r;
    r = 0;
    case (off)
      2'd0: begin
        r[0] = m_en; r[2:1] = m_mode; r[3] = m_im;
`ifdef TC_STATUS_READ_EN
        r[5:4] = 2'(int'(m_ph));
        r[6]   = m_flag;
`endif
      end
      2'd1: r = m_preset;
      2'd2: r = m_count;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Apply the timer rules for one rising edge, using pre-edge values.
  task automatic model_edge(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    phase_t      n_ph = m_ph;
    logic [31:0] n_count = m_count;
    logic        n_en = m_en, n_flag = m_flag;
    logic        expire = 0;
    case (m_ph)
      P_IDLE: if (m_en) n_ph = P_LOAD;
      P_LOAD: begin n_count = m_preset; n_ph = P_CNT; end
      P_CNT: begin
        if (!m_en) n_ph = P_IDLE;
        else if (m_count > 1) n_count = m_count - 1;
        else begin n_count = 0; n_flag = 1; expire = 1; n_ph = P_INT; end
      end
      P_INT: begin
        if (m_mode == 2'b01) n_flag = 0;
        else n_en = 0;
        n_ph = P_IDLE;
      end
      default: n_ph = P_IDLE;
    endcase
    if (we && addr[3:2] == 2'd0) begin
      n_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3];
      if (!expire) n_flag = 0;
    end
    if (we && addr[3:2] == 2'd1) m_preset = wdata;
    m_ph = n_ph; m_count = n_count; m_en = n_en; m_flag = n_flag;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.we = we; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    model_edge(we, addr, wdata);
    #1;
    bus.we = 0;
    bus.addr = $urandom;
    #1;
    exp_q.push_back(model_read(bus.addr[3:2]));
    exp_q.push_back({31'b0, m_im & m_flag});
    exp_q.push_back(32'(int'(m_ph)));
    check("rdata", bus.rdata, exp_q.pop_front());
    check("irq", {31'b0, bus.irq}, exp_q.pop_front());
    check("state", {30'b0, state_dbg}, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.addr = addr;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 0;
    #1;
    check("rst_irq", {31'b0, bus.irq}, 0);
    read_check("rst_ctrl", 32'h0, 0);
    read_check("rst_count", 32'h8, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [1:0] off);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = off;
    return a;
  endfunction

  int prev, pulses, r;

  initial begin
    reset_n = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    model_reset();
    #3;
    read_check("init_ctrl", 32'h0, 0);
    read_check("init_preset", 32'h4, 0);
    read_check("init_count", 32'h8, 0);
    check("init_irq", {31'b0, bus.irq}, 0);
    @(negedge clk);
    reset_n = 1;

    // One-shot, PRESET=5: irq 6 edges after LOAD, held, EN auto-cleared
    cycle(1, mk_addr(2'd1), 5);
    cycle(1, mk_addr(2'd0), 32'h9);
    idle(6);
    check("os_irq_early", {31'b0, bus.irq}, 0);
    idle(1);
    check("os_irq_rise", {31'b0, bus.irq}, 1);
    idle(3);
    check("os_irq_held", {31'b0, bus.irq}, 1);
    read_check("os_en_clear", 32'h0, 32'h8 | (model_read(2'd0) & 32'h70));
    cycle(1, mk_addr(2'd0), 32'h0);
    check("os_irq_drop", {31'b0, bus.irq}, 0);
    read_check("os_count0", 32'h8, 0);

    // Auto-reload, PRESET=3: one-cycle pulses every 6 cycles
    cycle(1, mk_addr(2'd1), 3);
    cycle(1, mk_addr(2'd0), 32'hB);
    prev = -1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (bus.irq) begin
        if (prev >= 0) check("ar_period", i - prev, 6);
        prev = i;
        pulses++;
      end
    end
    check("ar_pulses", pulses, 5);
    cycle(1, mk_addr(2'd0), 32'h0);

    // Mid-count disable freezes COUNT, then reload from new PRESET
    cycle(1, mk_addr(2'd1), 10);
    cycle(1, mk_addr(2'd0), 32'h9);
    for (int i = 0; i < 20 && !(m_ph == P_CNT && m_count == 4); i++) idle(1);
    cycle(1, mk_addr(2'd0), 32'h8);
    idle(3);
    check("mid_frozen_state", {30'b0, state_dbg}, 0);
    read_check("mid_frozen_count", 32'h8, m_count);
    check("mid_no_irq", {31'b0, bus.irq}, 0);
    cycle(1, mk_addr(2'd1), 7);
    cycle(1, mk_addr(2'd0), 32'h9);
    idle(2);
    read_check("reload7", 32'h8, 7);

    // Ignored writes to COUNT and offset 0xC
    cycle(1, 32'h8, 32'hFFFF);
    cycle(1, 32'hC, 32'hFFFF);
    read_check("off_c_read", 32'hC, 0);

    // CTRL write clearing EN on the expiry edge: flag still sets
    cycle(1, mk_addr(2'd0), 32'h0);
    cycle(1, mk_addr(2'd1), 1);
    cycle(1, mk_addr(2'd0), 32'h9);
    idle(2);
    cycle(1, mk_addr(2'd0), 32'h8);
    check("simul_irq", {31'b0, bus.irq}, 1);
    idle(2);

    // Reset while irq is held asserted
    cycle(1, mk_addr(2'd1), 2);
    cycle(1, mk_addr(2'd0), 32'h9);
    idle(5);
    check("pre_rst_irq", {31'b0, bus.irq}, 1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[0] = 1;
        cycle(1, mk_addr(2'd0), w);
      end else if (r < 10) begin
        cycle(1, mk_addr(2'd1), $urandom_range(0, 9));
      end else if (r < 12) begin
        cycle(1, mk_addr(2'($urandom_range(2, 3))), $urandom);
      end else if (r < 13) begin
        do_reset();
      end else begin
        idle(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
